// File: rtl/filter_ingress_arbiter_if.sv
// Stream bundle around the ingress arbiter: NUM_SRC source channels in, one tagged channel out.
// slave = arbiter view, master = view of the surrounding sources and downstream filter.
interface filter_ingress_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 128
);
    localparam int ID_WIDTH = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]            s_tvalid;
    logic [NUM_SRC-1:0]            s_tready;
    logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata;
    logic [NUM_SRC-1:0]            s_tlast;
    logic                          m_tvalid;
    logic                          m_tready;
    logic [DATA_WIDTH-1:0]         m_tdata;
    logic                          m_tlast;
    logic [ID_WIDTH-1:0]           m_tid;

    modport slave (
        input  s_tvalid, s_tdata, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast, m_tid
    );

    modport master (
        output s_tvalid, s_tdata, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast, m_tid
    );
endinterface

// File: rtl/filter_ingress_arbiter.sv
// Packet-granular round-robin arbiter feeding one filter input; grant is locked from first beat to tlast.
// One registered output beat with source ID; one arbitration bubble per packet.
module filter_ingress_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 128
) (
    input  logic                     aclk,
    input  logic                     arst_n,
    filter_ingress_arbiter_if.slave  bus,
    output logic                     busy
);
    localparam int ID_WIDTH = $clog2(NUM_SRC);

    typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [ID_WIDTH-1:0]   out_tid_q, out_tid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic [ID_WIDTH-1:0]   pick_idx;
    logic                  pick_found;
    int                    cand;
    logic                  load_ok;
    logic                  src_hs;
    logic                  grant_valid;
    logic                  grant_last;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [NUM_SRC-1:0]    s_tready_w;

    // Output slot can take a beat when empty or draining this cycle.
    assign load_ok     = !out_valid_q || bus.m_tready;
    assign grant_valid = bus.s_tvalid[grant_q];
    assign grant_last  = bus.s_tlast[grant_q];
    assign grant_data  = bus.s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign src_hs      = (state_q == ST_LOCK) && grant_valid && load_ok;

    // First valid source at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        pick_idx   = rr_ptr_q;
        pick_found = 1'b0;
        cand       = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_SRC;
            if (!pick_found && bus.s_tvalid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = ID_WIDTH'(cand);
            end
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_ARB;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_tid_q   <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_tid_q   <= out_tid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        case (state_q)
            ST_ARB: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (src_hs && grant_last) begin
                    state_d  = ST_ARB;
                    rr_ptr_d = (grant_q == ID_WIDTH'(NUM_SRC-1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Single-entry output register: load on grant handshake, otherwise drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_tid_d   = out_tid_q;
        out_data_d  = out_data_q;
        if (src_hs) begin
            out_valid_d = 1'b1;
            out_last_d  = grant_last;
            out_tid_d   = grant_q;
            out_data_d  = grant_data;
        end else if (out_valid_q && bus.m_tready) begin
            out_valid_d = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
            assign s_tready_w[gi] = (state_q == ST_LOCK) && (grant_q == ID_WIDTH'(gi)) && load_ok;
        end
    endgenerate

    always_comb begin
        bus.s_tready = s_tready_w;
        bus.m_tvalid = out_valid_q;
        bus.m_tdata  = out_valid_q ? out_data_q : '0;
        bus.m_tlast  = out_valid_q && out_last_q;
        bus.m_tid    = out_valid_q ? out_tid_q : '0;
        busy         = (state_q == ST_LOCK);
    end
endmodule

// File: tb/tb_filter_ingress_arbiter.sv
// Bench for filter_ingress_arbiter: per-source beat queues, expected-beat scoreboard,
// a table of round-robin arbitration vectors and hand-written multi-cycle sequences.
module tb_filter_ingress_arbiter;
    localparam int NS = 4;
    localparam int DW = 128;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [1:0]    tid;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        int         n;
        logic [7:0] order;
    } rr_vec_t;

    logic aclk = 1'b0;
    logic arst_n = 1'b1;
    logic busy;

    filter_ingress_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) bus ();

    filter_ingress_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW)) dut (
        .aclk   (aclk),
        .arst_n (arst_n),
        .bus    (bus.slave),
        .busy   (busy)
    );

    always #5 aclk = ~aclk;

    int      n_checks = 0;
    int      n_fail   = 0;
    beat_t   src_q[NS][$];
    exp_t    exp_q[$];
    logic [3:0]    hs_src = '0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic [1:0]    prev_tid = '0;
    int      tcyc = 0;
    int      stall_from = 0, stall_to = 0;
    int      gap_from = 0, gap_to = 0;
    logic [3:0] gap_mask = '0;
    rr_vec_t tbl[6];

    function automatic logic [DW-1:0] mk(input int s, input int p, input int b);
        return {32'hFACE_B00C, 32'(p), 32'(s), 32'(b)};
    endfunction

    task automatic chk_eq(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic sample_checks();
        exp_t e;
        hs_src = bus.s_tvalid & bus.s_tready;
        if (prev_stall) begin
            chk_eq("hold_valid", DW'(bus.m_tvalid), DW'(1));
            chk_eq("hold_data", bus.m_tdata, prev_data);
            chk_eq("hold_last_tid", DW'({bus.m_tlast, bus.m_tid}), DW'({prev_last, prev_tid}));
        end
        if (!bus.m_tvalid) begin
            chk_eq("idle_data", bus.m_tdata, '0);
            chk_eq("idle_last_tid", DW'({bus.m_tlast, bus.m_tid}), '0);
        end
        chk_eq("tready_onehot", DW'($countones(bus.s_tready) <= 1), DW'(1));
        if (!busy) chk_eq("arb_tready_zero", DW'(bus.s_tready), '0);
        if (bus.m_tvalid && !bus.m_tready) chk_eq("stall_tready_zero", DW'(bus.s_tready), '0);
        if (bus.m_tvalid && bus.m_tready) begin
            if (exp_q.size() == 0) begin
                fail_now("sb_unexpected_beat");
            end else begin
                e = exp_q.pop_front();
                chk_eq("beat_data", bus.m_tdata, e.data);
                chk_eq("beat_last", DW'(bus.m_tlast), DW'(e.last));
                chk_eq("beat_tid", DW'(bus.m_tid), DW'(e.tid));
            end
        end
        prev_stall = bus.m_tvalid && !bus.m_tready;
        prev_data  = bus.m_tdata;
        prev_last  = bus.m_tlast;
        prev_tid   = bus.m_tid;
    endtask

    // One clock: retire accepted source beats, drive next inputs, sample on the falling edge.
    task automatic cycle();
        logic [NS-1:0]    v;
        logic [NS-1:0]    l;
        logic [NS*DW-1:0] d;
        @(posedge aclk);
        #1;
        for (int i = 0; i < NS; i++)
            if (hs_src[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0 && !(gap_mask[i] && tcyc >= gap_from && tcyc < gap_to)) begin
                v[i]           = 1'b1;
                d[i*DW +: DW]  = src_q[i][0].data;
                l[i]           = src_q[i][0].last;
            end
        end
        bus.s_tvalid = v;
        bus.s_tdata  = d;
        bus.s_tlast  = l;
        bus.m_tready = !(tcyc >= stall_from && tcyc < stall_to);
        @(negedge aclk);
        sample_checks();
        tcyc++;
    endtask

    // Called on a falling edge; asserts reset for one full clock.
    task automatic do_reset();
        arst_n = 1'b0;
        for (int i = 0; i < NS; i++) src_q[i].delete();
        exp_q.delete();
        bus.s_tvalid = '0;
        bus.s_tdata  = '0;
        bus.s_tlast  = '0;
        bus.m_tready = 1'b1;
        hs_src = '0;
        prev_stall = 1'b0;
        tcyc = 0;
        stall_from = 0;
        stall_to = 0;
        gap_mask = '0;
        #1;
        chk_eq("rst_m_tvalid", DW'(bus.m_tvalid), '0);
        chk_eq("rst_s_tready", DW'(bus.s_tready), '0);
        chk_eq("rst_busy", DW'(busy), '0);
        chk_eq("rst_m_tid", DW'(bus.m_tid), '0);
        chk_eq("rst_m_tdata_last", bus.m_tdata | DW'(bus.m_tlast), '0);
        @(negedge aclk);
        arst_n = 1'b1;
    endtask

    function automatic bit all_idle();
        bit r = (exp_q.size() == 0) && !bus.m_tvalid;
        for (int i = 0; i < NS; i++) if (src_q[i].size() > 0) r = 1'b0;
        return r;
    endfunction

    task automatic drain(input string name, input int max);
        int k = 0;
        bit done = 1'b0;
        while (!done && k < max) begin
            cycle();
            k++;
            done = all_idle();
        end
        if (!done) fail_now({name, "_drain_timeout"});
    endtask

    task automatic push_pkt(input int s, input int p, input int nbeats);
        beat_t b;
        exp_t  e;
        for (int i = 0; i < nbeats; i++) begin
            b.data = mk(s, p, i);
            b.last = (i == nbeats - 1);
            src_q[s].push_back(b);
        end
    endtask

    task automatic expect_pkt(input int s, input int p, input int nbeats);
        exp_t e;
        for (int i = 0; i < nbeats; i++) begin
            e.data = mk(s, p, i);
            e.last = (i == nbeats - 1);
            e.tid  = 2'(s);
            exp_q.push_back(e);
        end
    endtask

    initial begin
        logic [5:0] tv, bz, tl;
        logic [7:0] ord;
        int         idx;
        int         k;
        beat_t      b;
        exp_t       e;

        // Single-beat packets offered together; expected grant order from the round-robin pointer.
        tbl[0] = '{4'b0100, 1, 8'h02};
        tbl[1] = '{4'b1111, 4, 8'h93};
        tbl[2] = '{4'b0011, 2, 8'h04};
        tbl[3] = '{4'b1001, 2, 8'h03};
        tbl[4] = '{4'b0110, 2, 8'h09};
        tbl[5] = '{4'b1010, 2, 8'h07};

        bus.s_tvalid = '0;
        bus.s_tdata  = '0;
        bus.s_tlast  = '0;
        bus.m_tready = 1'b1;

        // Reset state
        @(negedge aclk);
        do_reset();

        // Single source, 3 beats from src2
        for (int i = 0; i < 3; i++) begin
            b.data = {8'(8'hA1 + i), {15{8'h5A}}};
            b.last = (i == 2);
            src_q[2].push_back(b);
            e.data = b.data;
            e.last = b.last;
            e.tid  = 2'd2;
            exp_q.push_back(e);
        end
        tv = '0; bz = '0; tl = '0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            tv[c] = bus.m_tvalid;
            bz[c] = busy;
            tl[c] = bus.m_tlast;
        end
        chk_eq("single_m_tvalid_timeline", DW'(tv), DW'(6'b011100));
        chk_eq("single_busy_timeline", DW'(bz), DW'(6'b001110));
        chk_eq("single_m_tlast_timeline", DW'(tl), DW'(6'b010000));
        drain("single", 50);

        // Table-driven round-robin vectors from a fresh pointer
        @(negedge aclk);
        do_reset();
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < NS; s++)
                if (tbl[r].mask[s]) push_pkt(s, 100 + r, 1);
            ord = tbl[r].order;
            for (int j = 0; j < tbl[r].n; j++) begin
                idx = int'(ord[2*j +: 2]);
                expect_pkt(idx, 100 + r, 1);
            end
            drain("rr_table", 100);
        end

        // All four sources with continuous 2-beat packets: order 0,1,2,3,0,1,2,3
        @(negedge aclk);
        do_reset();
        for (int s = 0; s < NS; s++)
            for (int p = 0; p < 2; p++) push_pkt(s, p, 2);
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < NS; s++) expect_pkt(s, p, 2);
        drain("rr_continuous", 200);

        // Backpressure mid-packet from src1
        @(negedge aclk);
        do_reset();
        stall_from = 3;
        stall_to   = 8;
        push_pkt(1, 20, 4);
        expect_pkt(1, 20, 4);
        for (int c = 0; c < 6; c++) cycle();
        chk_eq("bp_held_valid", DW'(bus.m_tvalid), DW'(1));
        chk_eq("bp_held_data", bus.m_tdata, mk(1, 20, 1));
        chk_eq("bp_src1_tready", DW'(bus.s_tready[1]), '0);
        drain("backpressure", 100);

        // src0 gap mid-packet while src3 waits
        @(negedge aclk);
        do_reset();
        gap_mask = 4'b0001;
        gap_from = 3;
        gap_to   = 6;
        push_pkt(0, 30, 4);
        push_pkt(3, 31, 2);
        expect_pkt(0, 30, 4);
        expect_pkt(3, 31, 2);
        k = 0;
        while (src_q[0].size() > 0 && k < 30) begin
            idx = tcyc;
            cycle();
            k++;
            chk_eq("gap_src3_tready", DW'(bus.s_tready[3]), '0);
            if (idx == 4) chk_eq("gap_grant_held", DW'({busy, bus.s_tready[0], bus.s_tvalid[0]}), DW'(3'b110));
        end
        if (k >= 30) fail_now("gap_timeout");
        drain("gap", 100);

        // Reset during beat 2 of a 4-beat src1 packet, pointer previously moved to 3
        @(negedge aclk);
        do_reset();
        push_pkt(2, 40, 1);
        expect_pkt(2, 40, 1);
        drain("pre_reset", 50);
        push_pkt(1, 41, 4);
        expect_pkt(1, 41, 4);
        for (int c = 0; c < 3; c++) cycle();
        chk_eq("midpkt_before_reset", DW'({bus.m_tvalid, bus.s_tready[1]}), DW'(2'b11));
        do_reset();
        push_pkt(1, 42, 1);
        push_pkt(3, 43, 1);
        expect_pkt(1, 42, 1);
        expect_pkt(3, 43, 1);
        drain("post_reset", 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
